// File: rtl/bconv_pkg.sv
// Shared types and helpers for the binary-weight conv/ReLU stage.
// Holds the FSM encoding and width helpers.
package bconv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int MAX_IMG_W = 28;

  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bconv_line_buf.sv
// K-1 row delay lines plus a KxK window of registers.
// Tap r*K+c is row r (top=0), col c (left=0).
module bconv_line_buf
  import bconv_pkg::*;
#(
  parameter int K     = 5,
  parameter int DIN_W = 32,
  parameter int MAX_W = MAX_IMG_W,
  parameter int CW    = cw(MAX_W + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   shift,
  input  logic [CW-1:0]          w,
  input  logic [DIN_W-1:0]       din,
  output logic [K*K*DIN_W-1:0]   win_flat
);

  logic [DIN_W-1:0] mem [K-1][MAX_W];
  logic [DIN_W-1:0] fout [K-1];
  logic [DIN_W-1:0] col_in [K];
  logic [DIN_W-1:0] win [K][K];
  logic [CW-1:0]    ptr;

  // delay-line taps and the new window column
  always_comb begin
    for (int j = 0; j < K-1; j++) begin
      fout[j] = mem[j][ptr];
    end
    col_in[K-1] = din;
    for (int r = 0; r < K-1; r++) begin
      col_in[r] = fout[K-2-r];
    end
  end

  // circular pointer shared by all rows, wraps at W
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (shift) begin
      ptr <= (ptr == w - CW'(1)) ? '0 : ptr + CW'(1);
    end
  end

  // row storage: each row delays its input by exactly W shifts
  always_ff @(posedge clk) begin
    if (shift) begin
      mem[0][ptr] <= din;
      for (int j = 1; j < K-1; j++) begin
        mem[j][ptr] <= fout[j-1];
      end
    end
  end

  // window slides left, new column enters on the right
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (shift) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K-1] <= col_in[r];
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_r
    for (genvar c = 0; c < K; c++) begin : g_c
      assign win_flat[(r*K+c)*DIN_W +: DIN_W] = win[r][c];
    end
  end

endmodule

// File: rtl/bconv_relu_core.sv
// Binary-weight KxK conv with ReLU, shift and saturation.
// Raster stream in, one activation per valid window out.
module bconv_relu_core
  import bconv_pkg::*;
#(
  parameter int DIN_W     = 32,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 32,
  parameter int K         = 5,
  parameter int IMG_W0    = 28,
  parameter int IMG_W1    = 12,
  parameter int OUT_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             weight_en,
  input  logic             weight,
  input  logic             start,
  input  logic             mode,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             done,
  output logic             busy,
  output logic             weights_loaded
);

  localparam int MAX_W = max_w(IMG_W0, IMG_W1);
  localparam int CW    = cw(MAX_W + 1);
  localparam int NT    = K * K;
  localparam int TW    = cw(NT);

  state_t                   state;
  logic [NT-1:0]            wts;
  logic [TW-1:0]            widx;
  logic [CW-1:0]            w_img;
  logic [CW-1:0]            row;
  logic [CW-1:0]            col;
  logic                     stall;
  logic                     accept;
  logic                     win_ok;
  logic                     last_px;
  logic                     go;
  logic [NT*DIN_W-1:0]      win_flat;
  logic                     v0, l0, v1, l1;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  s1_sum;
  logic signed [DIN_W-1:0]  px;
  logic signed [ACC_W-1:0]  term;
  logic [ACC_W-1:0]         relu;
  logic [ACC_W-1:0]         shifted;
  logic [OUT_W-1:0]         sat;

  assign stall     = dout_valid & ~dout_ready;
  assign din_ready = (state == RUN) & ~stall;
  assign accept    = din_valid & din_ready;
  assign busy      = (state != IDLE);
  assign go        = (state == IDLE) & start & weights_loaded;
  assign win_ok    = (row >= CW'(K-1)) && (col >= CW'(K-1));
  assign last_px   = (row == w_img - CW'(1)) && (col == w_img - CW'(1));

  bconv_line_buf #(
    .K     (K),
    .DIN_W (DIN_W),
    .MAX_W (MAX_W),
    .CW    (CW)
  ) u_lb (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (go),
    .shift    (accept),
    .w        (w_img),
    .din      (din),
    .win_flat (win_flat)
  );

  // weight load, frame FSM and raster counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      wts            <= '0;
      widx           <= '0;
      weights_loaded <= 1'b0;
      w_img          <= '0;
      row            <= '0;
      col            <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (weight_en) begin
            wts[widx] <= weight;
            if (widx == TW'(NT-1)) begin
              widx           <= '0;
              weights_loaded <= 1'b1;
            end else begin
              widx           <= widx + TW'(1);
              weights_loaded <= 1'b0;
            end
          end
          if (go) begin
            state <= RUN;
            w_img <= mode ? CW'(IMG_W1) : CW'(IMG_W0);
            row   <= '0;
            col   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (col == w_img - CW'(1)) begin
              col <= '0;
              row <= row + CW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (last_px) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dout_valid & dout_ready & done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // signed sum of +/- taps over the current window
  always_comb begin
    sum  = '0;
    px   = '0;
    term = '0;
    for (int t = 0; t < NT; t++) begin
      px   = win_flat[t*DIN_W +: DIN_W];
      term = {{(ACC_W-DIN_W){px[DIN_W-1]}}, px};
      sum  = wts[t] ? sum + term : sum - term;
    end
  end

  // ReLU, logical shift, clamp to the output range
  always_comb begin
    relu    = s1_sum[ACC_W-1] ? '0 : s1_sum;
    shifted = relu >> OUT_SHIFT;
    sat     = (|(shifted >> OUT_W)) ? '1 : shifted[OUT_W-1:0];
  end

  // valid tag, adder register, output register; all hold on stall
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v0         <= 1'b0;
      l0         <= 1'b0;
      v1         <= 1'b0;
      l1         <= 1'b0;
      s1_sum     <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      dout       <= '0;
    end else if (!stall) begin
      v0         <= accept & win_ok;
      l0         <= accept & last_px;
      v1         <= v0;
      l1         <= l0;
      s1_sum     <= sum;
      dout_valid <= v1;
      done       <= v1 & l1;
      if (v1) dout <= sat;
    end
  end

endmodule

// File: doc/bconv_relu_core.md
# bconv_relu_core

Parametrised binary-weight K×K convolution stage with an internal line buffer, ReLU, output shift/saturation and ready/valid handshakes on both sides. It takes a raster pixel stream of a square image, whose width is selected per frame by `mode`, and emits one activation per valid window position in raster order. It sits between the input stream source and the pooling stage in the BNN datapath. It replaces the fixed-size conv/window wrapper and its hard-coded start delays with internally generated window validity.

## Interface
- `DIN_W`, 32: signed input pixel width.
- `ACC_W`, 40: signed accumulator width; must be ≥ DIN_W + clog2(K*K).
- `OUT_W`, 32: unsigned output width.
- `K`, 5: kernel size; the window is K×K.
- `IMG_W0`, 28: image width/height when mode=0.
- `IMG_W1`, 12: image width/height when mode=1.
- `OUT_SHIFT`, 0: right shift applied after ReLU.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: asynchronous, active-low reset.
- `weight_en` in 1: weight bit strobe.
- `weight` in 1: weight bit; 1 = +1, 0 = −1.
- `start` in 1: frame start pulse.
- `mode` in 1: image-size select, sampled at start.
- `din` in DIN_W: signed pixel.
- `din_valid` in 1: pixel valid.
- `din_ready` out 1: pixel accepted when valid&ready.
- `dout` out OUT_W: activation.
- `dout_valid` out 1: output valid.
- `dout_ready` in 1: output consumer ready.
- `done` out 1: high with the last output beat of a frame.
- `busy` out 1: frame in progress.
- `weights_loaded` out 1: all K*K weight bits have been received.

## Operation
- Weight load happens only in IDLE.
  - Each `weight_en` cycle shifts in one bit, row-major, first bit = top-left tap.
  - `weights_loaded` sets after K*K bits.
  - Further bits restart the load from tap 0 and clear `weights_loaded` until K*K bits are in again.
  - `weight_en` outside IDLE is ignored.
- States:
  - IDLE → RUN on `start` with `weights_loaded`=1. W is latched from `mode`, and the row/col counters are cleared.
  - A `start` without weights, or while `busy`, is ignored.
  - RUN: accepts pixels. Col counts 0..W−1 and wraps, incrementing row.
  - RUN → DRAIN after the pixel at (W−1, W−1) is accepted.
  - DRAIN → IDLE when the last output beat is accepted; `done` is asserted on that beat.
- A window is valid when the accepted pixel has row ≥ K−1 and col ≥ K−1. This gives (W−K+1)² outputs per frame: 576 for W=28, K=5.
- Arithmetic:
  - Sum over taps of (w ? +din : −din), each term sign-extended to ACC_W.
  - ReLU: a negative sum becomes 0.
  - Then logical shift right by OUT_SHIFT.
  - Values above 2^OUT_W−1 saturate to 2^OUT_W−1.
- Line buffer holds K−1 rows of max(IMG_W0, IMG_W1) pixels; only the first W entries are used for the frame.
- Reset mid-operation returns the block to IDLE and clears weights, counters, pipeline and outputs. A new weight load is required after reset.

## Timing
- Reset values: `din_ready`=0, `dout`=0, `dout_valid`=0, `done`=0, `busy`=0, `weights_loaded`=0.
- `busy` is 1 from the cycle after an accepted `start` until the cycle after `done`.
- `din_ready` = (state==RUN) & !stall, where stall = `dout_valid` & !`dout_ready`.
- Pipeline is 2 stages: window adder tree register, then ReLU/shift/saturate output register.
  - The pixel completing a window, accepted at edge t, gives `dout_valid` after edge t+2 when there is no stall.
- During a stall, both stages and the line buffer hold. `dout` and `done` stay stable until accepted.
- Pixels whose window is invalid advance the line buffer but produce no output beat.
- `start` in the same cycle as the final accepted output beat is ignored, because the block is not yet in IDLE.
- `done` is a single beat: high only while `dout_valid` carries the last window.

## Structure
- Package `bconv_pkg`:
  - state enum {IDLE, RUN, DRAIN};
  - `clog2`-based counter-width function;
  - localparam for the maximum image width.
- Sub-module `bconv_line_buf` (K, DIN_W, MAX_W): K−1 row FIFOs plus K×K window registers, with a shift-enable and a `W` input. It exposes the flattened K*K window.
- Top level holds the weight shift register, FSM, counters, adder tree and output stage.

## Test plan
- K=5, W=28, all weights 1, din=1 constant, dout_ready=1: 576 beats, each `dout`=25; `done` on beat 576; first `dout_valid` 2 cycles after pixel (4,4) is accepted.
- All weights 0, din=1: 576 beats with `dout`=0 (ReLU of −25).
- mode=1 (W=12), din = pixel index, alternating weights: 64 beats matching a reference model in raster order; `done` on beat 64.
- `dout_ready` held low for 10 cycles mid-frame: `dout` and `dout_valid` stable, `din_ready`=0, no beats lost or duplicated, final count = 576.
- OUT_W=8, OUT_SHIFT=0, din=100, weights 1: every `dout`=255 (sum 2500 saturated). With OUT_SHIFT=4: `dout`=156.
- `rstn` pulsed low at pixel 300: all outputs return to reset values immediately. `start` without reloading weights is ignored (`busy` stays 0). After reloading weights, a full frame passes.
